// File: rtl/uart_rcv_param.sv
// Parametrised UART receiver: 2-flop RX synchroniser, mid-bit sampling FSM,
// optional parity, stop-bit check, sticky error flags and a small receive FIFO.
module uart_rcv_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 2604,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RX,
    input  logic                          clr_rx_rdy,
    output logic                          rx_rdy,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    input  logic                          clr_err,
    output logic                          frm_err,
    output logic                          par_err,
    output logic                          ovr_err
);

    localparam int unsigned CW   = $clog2(BAUD_DIV);
    localparam int unsigned BW   = $clog2(DATA_BITS);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;

    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_m_q, rx_s_q, rx_p_q;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frm_err_q, frm_err_d;
    logic                 par_err_q, par_err_d;
    logic                 ovr_err_q, ovr_err_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic strobe, par_exp, frame_ok, frm_set, par_set, ovr_set;
    logic push, pop, full;

    assign strobe  = (baud_cnt_q == '0);
    assign par_exp = (PARITY == 2) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        frame_ok   = 1'b0;
        frm_set    = 1'b0;
        par_set    = 1'b0;

        if (state_q != IDLE) begin
            baud_cnt_d = strobe ? BAUD_LAST : baud_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Edge-triggered start: a held-low line cannot retrigger.
                if (rx_p_q && !rx_s_q) begin
                    state_d    = START;
                    baud_cnt_d = BAUD_HALF;
                    par_bad_d  = 1'b0;
                end
            end
            START: begin
                if (strobe) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (strobe) begin
                    par_bad_d = (rx_s_q != par_exp);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        frm_set = 1'b1;
                    end else if (par_bad_q) begin
                        par_set = 1'b1;
                    end else begin
                        frame_ok = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    always_comb begin
        pop      = clr_rx_rdy && (cnt_q != '0);
        full     = (cnt_q == CNT_FULL);
        push     = frame_ok && (!full || pop);
        ovr_set  = frame_ok && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        frm_err_d = frm_set | (frm_err_q & ~clr_err);
        par_err_d = par_set | (par_err_q & ~clr_err);
        ovr_err_d = ovr_set | (ovr_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rx_m_q     <= RX;
            rx_s_q     <= rx_m_q;
            rx_p_q     <= rx_s_q;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            frm_err_q  <= frm_err_d;
            par_err_q  <= par_err_d;
            ovr_err_q  <= ovr_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
        end
    end

    assign rx_rdy   = (cnt_q != '0);
    assign rx_data  = mem_q[rd_ptr_q];
    assign fifo_cnt = cnt_q;
    assign frm_err  = frm_err_q;
    assign par_err  = par_err_q;
    assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_uart_rcv_param.sv
// Directed bench for uart_rcv_param: one instance without parity, one with odd parity.
module tb_uart_rcv_param;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rx2 = 1'b1;
    logic       pop0 = 1'b0, pop2 = 1'b0;
    logic       clr0 = 1'b0, clr2 = 1'b0;
    logic       rdy0, rdy2, frm0, frm2, par0, par2, ovr0, ovr2;
    logic [7:0] data0, data2;
    logic [2:0] cnt0, cnt2;

    always #5 clk = ~clk;

    uart_rcv_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .RX(rx0), .clr_rx_rdy(pop0), .rx_rdy(rdy0),
        .rx_data(data0), .fifo_cnt(cnt0), .clr_err(clr0), .frm_err(frm0),
        .par_err(par0), .ovr_err(ovr0)
    );

    uart_rcv_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .RX(rx2), .clr_rx_rdy(pop2), .rx_rdy(rdy2),
        .rx_data(data2), .fifo_cnt(cnt2), .clr_err(clr2), .frm_err(frm2),
        .par_err(par2), .ovr_err(ovr2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic b);
        if (sel == 0) rx0 = b; else rx2 = b;
    endtask

    task automatic set_pop(input int sel, input logic b);
        if (sel == 0) pop0 = b; else pop2 = b;
    endtask

    task automatic set_clr(input int sel, input logic b);
        if (sel == 0) clr0 = b; else clr2 = b;
    endtask

    task automatic get(input int sel, output logic [2:0] cnt, output logic [7:0] d,
                       output logic rdy, output logic frm, output logic par, output logic ovr);
        if (sel == 0) begin
            cnt = cnt0; d = data0; rdy = rdy0; frm = frm0; par = par0; ovr = ovr0;
        end else begin
            cnt = cnt2; d = data2; rdy = rdy2; frm = frm2; par = par2; ovr = ovr2;
        end
    endtask

    // Stop-bit strobe lands on the 11th rising edge after the stop bit is driven.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic has_par,
                              input logic par_bit, input logic stop_bit,
                              input logic clr_at_stop, input logic pop_at_stop,
                              output logic [2:0] cnt_pre, output logic [2:0] cnt_post);
        logic [7:0] d;
        logic       r, f, p, o;
        set_rx(sel, 1'b0);
        wait_clk(BD);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, data[i]);
            wait_clk(BD);
        end
        if (has_par) begin
            set_rx(sel, par_bit);
            wait_clk(BD);
        end
        set_rx(sel, stop_bit);
        wait_clk(10);
        get(sel, cnt_pre, d, r, f, p, o);
        if (clr_at_stop) set_clr(sel, 1'b1);
        if (pop_at_stop) set_pop(sel, 1'b1);
        wait_clk(1);
        set_clr(sel, 1'b0);
        set_pop(sel, 1'b0);
        get(sel, cnt_post, d, r, f, p, o);
        wait_clk(5);
        if (!stop_bit) begin
            set_rx(sel, 1'b1);
            wait_clk(4);
        end
    endtask

    task automatic pop_one(input int sel);
        set_pop(sel, 1'b1);
        wait_clk(1);
        set_pop(sel, 1'b0);
    endtask

    task automatic clear_errs(input int sel);
        set_clr(sel, 1'b1);
        wait_clk(1);
        set_clr(sel, 1'b0);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       has_par;
        logic       par_bit;
        logic       stop_bit;
        logic [2:0] exp_cnt;
        logic [7:0] exp_data;
        logic       exp_frm;
        logic       exp_par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [2:0] pre, post, c;
        logic [7:0] d;
        logic       r, f, p, o;
        logic [7:0] exp_q[$];

        // Odd parity bit = ~XOR(data): 0x07 -> 0, 0x03 -> 1, 0x80 -> 0.
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{2, 8'h07, 1'b1, 1'b0, 1'b1, 3'd1, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{2, 8'h07, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{2, 8'h03, 1'b1, 1'b1, 1'b1, 3'd1, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{2, 8'h80, 1'b1, 1'b0, 1'b1, 3'd1, 8'h80, 1'b0, 1'b0};

        wait_clk(3);
        for (int s = 0; s <= 2; s += 2) begin
            get(s, c, d, r, f, p, o);
            chk("reset_cnt", c, 0);
            chk("reset_rdy", r, 0);
            chk("reset_data", d, 0);
            chk("reset_errs", {f, p, o}, 0);
        end
        rst_n = 1'b1;
        wait_clk(5);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].has_par, vecs[i].par_bit,
                       vecs[i].stop_bit, 1'b0, 1'b0, pre, post);
            chk($sformatf("v%0d_cnt_before_stop", i), pre, 0);
            chk($sformatf("v%0d_cnt", i), post, vecs[i].exp_cnt);
            get(vecs[i].sel, c, d, r, f, p, o);
            chk($sformatf("v%0d_rdy", i), r, (vecs[i].exp_cnt != 0));
            if (vecs[i].exp_cnt != 0) chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("v%0d_frm", i), f, vecs[i].exp_frm);
            chk($sformatf("v%0d_par", i), p, vecs[i].exp_par);
            chk($sformatf("v%0d_ovr", i), o, 0);
            pop_one(vecs[i].sel);
            clear_errs(vecs[i].sel);
            get(vecs[i].sel, c, d, r, f, p, o);
            chk($sformatf("v%0d_cnt_after_pop", i), c, 0);
            chk($sformatf("v%0d_errs_after_clr", i), {r, f, p}, 0);
        end

        // Short low glitch must be rejected as a false start.
        rx0 = 1'b0;
        wait_clk(4);
        rx0 = 1'b1;
        wait_clk(40);
        get(0, c, d, r, f, p, o);
        chk("glitch_cnt", c, 0);
        chk("glitch_errs", {r, f, p, o}, 0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pre, post);
        chk("after_glitch_cnt", post, 1);
        chk("after_glitch_data", data0, 8'h5A);
        pop_one(0);

        // Framing error, clear, then set-wins against a simultaneous clear.
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pre, post);
        chk("frm_set", frm0, 1);
        chk("frm_cnt", cnt0, 0);
        clear_errs(0);
        chk("frm_cleared", frm0, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pre, post);
        chk("frm_set_wins", frm0, 1);
        clear_errs(0);

        // Overflow: five frames into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pre, post);
        end
        chk("ovr_cnt", cnt0, 4);
        chk("ovr_flag", ovr0, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_pop%0d", i), data0, 8'(i));
            pop_one(0);
        end
        chk("ovr_drained_rdy", rdy0, 0);
        pop_one(0);
        chk("empty_pop_cnt", cnt0, 0);
        chk("ovr_still_set", ovr0, 1);
        clear_errs(0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) begin
            send_frame(0, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pre, post);
        end
        send_frame(0, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, pre, post);
        chk("full_pushpop_pre", pre, 4);
        chk("full_pushpop_cnt", post, 4);
        chk("full_pushpop_ovr", ovr0, 0);
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
        foreach (exp_q[i]) begin
            chk($sformatf("full_pushpop_pop%0d", i), data0, exp_q[i]);
            pop_one(0);
        end
        chk("full_pushpop_empty", cnt0, 0);

        // Reset in the middle of a frame with a queued entry and a sticky flag.
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pre, post);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pre, post);
        chk("pre_reset_state", {cnt0, frm0}, {3'd1, 1'b1});
        rx0 = 1'b0;
        wait_clk(BD);
        rx0 = 1'b1; wait_clk(BD);
        rx0 = 1'b0; wait_clk(BD);
        rx0 = 1'b1; wait_clk(BD / 2);
        rst_n = 1'b0;
        wait_clk(3);
        chk("midreset_cnt", cnt0, 0);
        chk("midreset_errs", {rdy0, frm0, par0, ovr0}, 0);
        rst_n = 1'b1;
        wait_clk(20);
        chk("postreset_idle_cnt", cnt0, 0);
        send_frame(0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pre, post);
        chk("postreset_cnt", post, 1);
        chk("postreset_data", data0, 8'h99);
        chk("postreset_errs", {frm0, par0, ovr0}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
